shift_reg_univ: RTL

Parametrised universal shift register, successor to the fixed 8-bit serial-in shift register. Supports hold, shift-right, shift-left and parallel-load modes, with serial inputs and outputs at both ends, a synchronous clear and a clock enable. An internal shift counter flags each completed WIDTH-bit serial word, so the block works as a serial-to-parallel deserialiser or as a parallel-to-serial serialiser in the training designs.

---
 rtl/shift_reg_pkg.sv | 9 +
 rtl/shift_reg_univ.sv | 100 ++++++++++
 2 files changed

// File: rtl/shift_reg_pkg.sv
// Shared definitions for the universal shift register: operation-select encodings.
package shift_reg_pkg;

   localparam logic [1:0] MODE_HOLD = 2'b00;
   localparam logic [1:0] MODE_SHR  = 2'b01;
   localparam logic [1:0] MODE_SHL  = 2'b10;
   localparam logic [1:0] MODE_LOAD = 2'b11;

endpackage : shift_reg_pkg

// File: rtl/shift_reg_univ.sv
// Universal shift register (hold / shift right / shift left / parallel load) with a
// shift counter that snapshots and flags every completed WIDTH-bit serial word.
module shift_reg_univ
   import shift_reg_pkg::*;
#(
   parameter  int WIDTH = 8,
   localparam int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_en,
   input  logic             i_clr,
   input  logic [1:0]       i_mode,
   input  logic             i_sin_msb,
   input  logic             i_sin_lsb,
   input  logic [WIDTH-1:0] i_data,
   output logic [WIDTH-1:0] o_data,
   output logic             o_q_msb,
   output logic             o_q_lsb,
   output logic [WIDTH-1:0] o_word,
   output logic             o_word_vld,
   output logic [CNT_W-1:0] o_cnt
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   logic [WIDTH-1:0] data_q, data_d;
   logic [WIDTH-1:0] word_q, word_d;
   logic [WIDTH-1:0] shifted;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             vld_q, vld_d;
   logic             do_shift;

   always_comb begin
      // NOTE: every signal written here gets a default first, so no path infers a latch.
      data_d   = data_q;
      cnt_d    = cnt_q;
      word_d   = word_q;
      vld_d    = 1'b0;
      shifted  = data_q;
      do_shift = 1'b0;

      if (i_clr) begin
         data_d = '0;
         cnt_d  = '0;
      end else if (i_en) begin
         case (i_mode)
            MODE_HOLD: ;
            MODE_SHR: begin
               shifted  = {i_sin_msb, data_q[WIDTH-1:1]};
               do_shift = 1'b1;
            end
            MODE_SHL: begin
               shifted  = {data_q[WIDTH-2:0], i_sin_lsb};
               do_shift = 1'b1;
            end
            MODE_LOAD: begin
               data_d = i_data;
               cnt_d  = '0;
            end
            default: ;
         endcase
      end

      // Either direction counts toward the same word; the snapshot is the post-shift value.
      if (do_shift) begin
         data_d = shifted;
         if (cnt_q == CNT_LAST) begin
            cnt_d  = '0;
            word_d = shifted;
            vld_d  = 1'b1;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         data_q <= '0;
         word_q <= '0;
         cnt_q  <= '0;
         vld_q  <= 1'b0;
      end else begin
         // NOTE: state registers use non-blocking assignments so all flops update together.
         data_q <= data_d;
         word_q <= word_d;
         cnt_q  <= cnt_d;
         vld_q  <= vld_d;
      end
   end

   assign o_data     = data_q;
   assign o_q_msb    = data_q[WIDTH-1];
   assign o_q_lsb    = data_q[0];
   assign o_word     = word_q;
   assign o_word_vld = vld_q;
   assign o_cnt      = cnt_q;

endmodule : shift_reg_univ
